imem_arbiter: RTL
=================

Name: imem_arbiter

Overview:
- Shares the single synchronous-read instruction ROM between two requesters: the CPU instruction-fetch port (IF) and a data-side read port (D), used by loads from instruction space and by the debug/loader path.
- The ROM registers its word address on posedge clk; data appears combinationally from that registered address one cycle later.
- This block arbitrates per cycle, drives the ROM address, and routes the returned word to the winner with a one-cycle rvalid pulse.
- Fixed data-over-fetch priority, with an aging counter so fetch is never starved.

Parameters:
- AW, 30, word-address width (matches ROM address port).
- DW, 32, instruction/data width.
- MAX_WAIT, 4, consecutive denied fetch cycles before fetch is promoted over D; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  AW  fetch word address; stable while if_req high.
- if_gnt  out  1  fetch granted this cycle (combinational).
- if_rvalid  out  1  if_rdata valid (one-cycle pulse).
- if_rdata  out  DW  returned word for fetch.
- d_req  in  1  data-port request; held until granted.
- d_addr  in  AW  data-port word address.
- d_gnt  out  1  data port granted this cycle (combinational).
- d_rvalid  out  1  d_rdata valid (one-cycle pulse).
- d_rdata  out  DW  returned word for data port.
- rom_addr  out  AW  address to ROM (ROM registers it).
- rom_inst  in  DW  ROM output word, corresponding to the address presented on the previous cycle.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. rst is sampled on posedge clk.
- While rst is high:
  - if_gnt = d_gnt = 0; rom_addr = 0.
  - On the reset edge: resp_owner <= NONE, starve_cnt <= 0, addr_hold <= 0.
  - After the edge: if_rvalid = d_rvalid = 0, and if_rdata/d_rdata = 0 when not valid.
- Arbitration (combinational, every cycle rst=0):
  - promote = (starve_cnt == MAX_WAIT).
  - If d_req and if_req: d wins unless promote, in which case IF wins.
  - If only one requester is active, it wins. If neither, no grant.
  - At most one of if_gnt/d_gnt is high. A transfer occurs when req and gnt are both high.
- ROM address:
  - rom_addr = winner's address when a grant is given, else addr_hold.
  - addr_hold <= rom_addr every cycle, so the ROM input is stable when idle.
- Response pipeline:
  - resp_owner (NONE/IF/D) is registered from the grant.
  - On the next cycle, the owner's rvalid = 1 and its rdata = rom_inst. The other port's rdata = 0.
  - Latency: exactly 1 cycle from grant to rvalid.
  - Back-to-back grants are allowed every cycle, giving full throughput.
  - No response backpressure: a requester must accept the data in the rvalid cycle.
- Aging counter (starve_cnt, 8 bits):
  - Increments when if_req && !if_gnt, saturating at MAX_WAIT.
  - Clears when if_gnt or !if_req.
- Boundaries:
  - Simultaneous requests with starve_cnt = MAX_WAIT-1: D wins; the counter then reaches MAX_WAIT, so IF wins on the next cycle.
  - A request withdrawn without a grant is a protocol violation; the block only clears the counter.
  - rst asserted while a response is pending: the pending rvalid is suppressed and no pulse is produced after reset.
  - Address wrap is the ROM's concern; no arithmetic is applied to addresses.

Optional Feature:
- Macro: IMEM_ARB_STATS_EN.
- When defined:
  - Adds output port conflict_cnt (16 bits).
  - It increments on every cycle with if_req && d_req && !rst, saturates at 16'hFFFF, and is cleared by rst.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then IF only: if_req=1, if_addr=0x3 → if_gnt=1 same cycle, rom_addr=0x3; next cycle if_rvalid=1, if_rdata=rom_inst (0x27bdffc8 with the current program image); d_rvalid=0.
- Streaming fetch of addresses 0x0..0x4 on consecutive cycles → five consecutive if_rvalid pulses, each one cycle after its grant, data in address order.
- Both requesting continuously, MAX_WAIT=4 → grant pattern D,D,D,D,IF repeating. starve_cnt reads 0,1,2,3,4 over the first five cycles and is cleared after the IF grant.
- Idle after a D grant to 0x2a → rom_addr holds 0x2a and no rvalid is asserted on either port.
- rst asserted the cycle after a grant → no rvalid on the following cycle, rom_addr=0, and starve_cnt=0 after release.
- With IMEM_ARB_STATS_EN, both ports request for 10 cycles → conflict_cnt=10. With the counter preloaded near 0xFFFF via a long run, it stays at 0xFFFF.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bundle of the two requester ports and the ROM port around imem_arbiter.
// slave = arbiter side, master = requesters plus ROM (the environment).
interface imem_arbiter_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_inst;

  // Handshake: a request (req + addr) is held stable until gnt is seen high in
  // the same cycle; req && gnt is the transfer. Exactly one cycle later the
  // owner sees rvalid with rdata, and must take it then (no backpressure).
  modport slave (
    input  if_req, if_addr, d_req, d_addr, rom_inst,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, rom_addr
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, rom_inst,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, rom_addr
  );
endinterface

// File: rtl/imem_arbiter.sv
// Per-cycle arbiter sharing the synchronous-read instruction ROM between fetch (IF) and data (D).
// Optional IMEM_ARB_STATS_EN adds a saturating conflict_cnt output.
module imem_arbiter #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  imem_arbiter_if.slave bus,
  output logic [1:0] dbg_resp_owner,
  output logic [7:0] dbg_starve_cnt
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [15:0] conflict_cnt
`endif
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [1:0]    resp_owner_q, resp_owner_d;
  logic [7:0]    starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] addr_hold_q, addr_hold_d;
  logic [AW-1:0] rom_addr_w;
  logic          promote, if_win, d_win;

  // D has priority unless fetch has waited MAX_WAIT consecutive cycles.
  always_comb begin
    promote = (starve_cnt_q == MAX_WAIT_C);
    if_win  = 1'b0;
    d_win   = 1'b0;
    if (!rst) begin
      if (bus.d_req && !(bus.if_req && promote)) d_win = 1'b1;
      else if (bus.if_req)                        if_win = 1'b1;
    end
  end

  always_comb begin
    rom_addr_w = addr_hold_q;
    if (rst)         rom_addr_w = '0;
    else if (if_win) rom_addr_w = bus.if_addr;
    else if (d_win)  rom_addr_w = bus.d_addr;
  end

  always_comb begin
    addr_hold_d  = rom_addr_w;
    resp_owner_d = OWN_NONE;
    if (if_win)     resp_owner_d = OWN_IF;
    else if (d_win) resp_owner_d = OWN_D;
    starve_cnt_d = 8'd0;
    if (bus.if_req && !if_win)
      starve_cnt_d = promote ? starve_cnt_q : 8'(starve_cnt_q + 8'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_owner_q <= OWN_NONE;
      starve_cnt_q <= 8'd0;
      addr_hold_q  <= '0;
    end else begin
      resp_owner_q <= resp_owner_d;
      starve_cnt_q <= starve_cnt_d;
      addr_hold_q  <= addr_hold_d;
    end
  end

  // rst also masks a response already in flight so no pulse leaks out.
  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.rom_addr  = rom_addr_w;
  assign bus.if_rvalid = !rst && (resp_owner_q == OWN_IF);
  assign bus.d_rvalid  = !rst && (resp_owner_q == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.rom_inst : '0;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.rom_inst : '0;

  assign dbg_resp_owner = resp_owner_q;
  assign dbg_starve_cnt = starve_cnt_q;

`ifdef IMEM_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (bus.if_req && bus.d_req && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_cnt_q <= 16'd0;
    else     conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
